// File: rtl/mini_dma.sv
`timescale 1ns/1ps
// mini_dma: single-channel byte-copy DMA engine.
//
// Copies LENGTH bytes from a 32-bit byte-addressed read bus into a
// 32-entry byte-addressed write bus, one byte at a time: each byte is read
// into a one-byte buffer, then written out, and both addresses advance.
//
// Ports
//   clock, aclr          sole clock; asynchronous active-high reset
//   ctl_*                control slave (word-indexed registers, zero-wait reads)
//                         0 STATUS  bit0 DONE (sticky), bit1 BUSY
//                         1 READADDRESS, 2 WRITEADDRESS, 3 LENGTH
//                         6 CONTROL bit0 GO (write-only)
//   rd_*                 read master (rd_read held with rd_address while stalled)
//   wm_*                 write master (active-low write, held while stalled)
//   irq                  mirrors STATUS.DONE
module mini_dma #(
    parameter int LEN_W = 16
) (
    input  logic        clock,
    input  logic        aclr,

    input  logic [2:0]  ctl_address,
    input  logic        ctl_chipselect,
    input  logic        ctl_write_n,
    input  logic [31:0] ctl_writedata,
    output logic [31:0] ctl_readdata,

    output logic [31:0] rd_address,
    output logic        rd_read,
    input  logic        rd_waitrequest,
    input  logic [7:0]  rd_readdata,

    output logic [4:0]  wm_address,
    output logic        wm_chipselect,
    output logic        wm_write_n,
    output logic [7:0]  wm_writedata,
    input  logic        wm_waitrequest,

    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_READ    = 3'd1;
    localparam logic [2:0] ADDR_WRITE   = 3'd2;
    localparam logic [2:0] ADDR_LENGTH  = 3'd3;
    localparam logic [2:0] ADDR_CONTROL = 3'd6;

    state_t           state;
    logic [31:0]      read_address;
    logic [4:0]       write_address;
    logic [LEN_W-1:0] length;
    logic [7:0]       buffer;
    logic             done;
    logic             busy;
    logic             ctl_wr;

    // A control write is a chip-selected cycle with write_n low.
    assign ctl_wr = ctl_chipselect & ~ctl_write_n;

    // The bus address/data outputs come straight from the holding registers,
    // so they are registered and naturally stay put through any stall.
    assign rd_address   = read_address;
    assign wm_address   = write_address;
    assign wm_writedata = buffer;
    assign irq          = done;

    // Zero-wait-state register readback; unmapped words and unused bits read 0.
    always_comb begin
        ctl_readdata = 32'd0;
        case (ctl_address)
            ADDR_STATUS: ctl_readdata = {30'd0, busy, done};
            ADDR_READ:   ctl_readdata = read_address;
            ADDR_WRITE:  ctl_readdata = {27'd0, write_address};
            ADDR_LENGTH: ctl_readdata = 32'(length);
            default:     ctl_readdata = 32'd0;
        endcase
    end

    // Register file and transfer FSM in one block.
    // A STATUS write clears DONE first in the block; any DONE-set later in
    // the same edge overrides it, so a completing transfer always wins.
    // Configuration and GO writes are only honoured in IDLE, which also
    // drops a GO that lands on the edge where WRITE finishes, since the FSM
    // is still in WRITE at that edge. The bus strobes are updated together
    // with the state so rd_read and wm_chipselect can never overlap.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state         <= IDLE;
            read_address  <= 32'd0;
            write_address <= 5'd0;
            length        <= '0;
            buffer        <= 8'd0;
            done          <= 1'b0;
            busy          <= 1'b0;
            rd_read       <= 1'b0;
            wm_chipselect <= 1'b0;
            wm_write_n    <= 1'b1;
        end else begin
            if (ctl_wr && ctl_address == ADDR_STATUS) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ctl_wr) begin
                        case (ctl_address)
                            ADDR_READ:   read_address  <= ctl_writedata;
                            ADDR_WRITE:  write_address <= ctl_writedata[4:0];
                            ADDR_LENGTH: length        <= LEN_W'(ctl_writedata);
                            ADDR_CONTROL: begin
                                if (ctl_writedata[0]) begin
                                    if (length != '0) begin
                                        state   <= READ;
                                        busy    <= 1'b1;
                                        rd_read <= 1'b1;
                                    end else begin
                                        done <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                READ: begin
                    if (!rd_waitrequest) begin
                        buffer        <= rd_readdata;
                        state         <= WRITE;
                        rd_read       <= 1'b0;
                        wm_chipselect <= 1'b1;
                        wm_write_n    <= 1'b0;
                    end
                end

                WRITE: begin
                    if (!wm_waitrequest) begin
                        read_address  <= read_address + 32'd1;
                        write_address <= write_address + 5'd1;
                        length        <= length - LEN_W'(1);
                        wm_chipselect <= 1'b0;
                        wm_write_n    <= 1'b1;
                        if (length == LEN_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= READ;
                            rd_read <= 1'b1;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    rd_read       <= 1'b0;
                    wm_chipselect <= 1'b0;
                    wm_write_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_dma.sv
`timescale 1ns/1ps
// tb_mini_dma: self-checking bench for mini_dma.
// A register table exercises the control map; hand-written runs cover
// zero-wait, wait-state, wrap, zero-length, busy-write and async-reset cases.
// Expected bus beats are queued when a run is set up and popped as the
// bus models accept each read and write.
module tb_mini_dma;

    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic [2:0]  ctl_address = 3'd0;
    logic        ctl_chipselect = 1'b0;
    logic        ctl_write_n = 1'b1;
    logic [31:0] ctl_writedata = 32'd0;
    logic [31:0] ctl_readdata;
    logic [31:0] rd_address;
    logic        rd_read;
    logic        rd_waitrequest = 1'b0;
    logic [7:0]  rd_readdata = 8'd0;
    logic [4:0]  wm_address;
    logic        wm_chipselect;
    logic        wm_write_n;
    logic [7:0]  wm_writedata;
    logic        wm_waitrequest = 1'b0;
    logic        irq;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_rec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata_exp;
        logic        do_write;
    } reg_vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cycle_count = 0;
    int          go_cycle = 0;
    int          rd_stall = 0;
    int          wm_stall = 0;
    int          rd_cnt = 0;
    int          wm_cnt = 0;
    int          bus_activity = 0;
    int          overlap_errs = 0;
    int          stall_errs = 0;
    int          write_count = 0;
    logic [31:0] exp_reads[$];
    wr_rec_t     exp_writes[$];
    int          write_offsets[$];
    logic        rd_stalled = 1'b0;
    logic        wm_stalled = 1'b0;
    logic [31:0] rd_hold = 32'd0;
    logic [4:0]  wa_hold = 5'd0;
    logic [7:0]  wd_hold = 8'd0;
    reg_vec_t    vecs[10];

    mini_dma #(.LEN_W(16)) dut (
        .clock          (clock),
        .aclr           (aclr),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write_n    (ctl_write_n),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .rd_address     (rd_address),
        .rd_read        (rd_read),
        .rd_waitrequest (rd_waitrequest),
        .rd_readdata    (rd_readdata),
        .wm_address     (wm_address),
        .wm_chipselect  (wm_chipselect),
        .wm_write_n     (wm_write_n),
        .wm_writedata   (wm_writedata),
        .wm_waitrequest (wm_waitrequest),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_count <= cycle_count + 1;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1004) return 8'hA1 + a[7:0];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        ctl_address    = a;
        ctl_writedata  = d;
        ctl_chipselect = 1'b1;
        ctl_write_n    = 1'b0;
        @(posedge clock);
        #1;
        ctl_chipselect = 1'b0;
        ctl_write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] d);
        ctl_address = a;
        #1;
        d = ctl_readdata;
    endtask

    task automatic setupRun(input logic [31:0] ra, input logic [4:0] wa, input int len);
        logic [31:0] r;
        logic [4:0]  w;
        applyStimulus(3'd1, ra);
        applyStimulus(3'd2, 32'(wa));
        applyStimulus(3'd3, 32'(len));
        r = ra;
        w = wa;
        for (int i = 0; i < len; i++) begin
            exp_reads.push_back(r);
            exp_writes.push_back('{w, mem_byte(r)});
            r = r + 32'd1;
            w = w + 5'd1;
        end
        write_offsets.delete();
        write_count = 0;
    endtask

    task automatic startGo();
        applyStimulus(3'd6, 32'd1);
        go_cycle = cycle_count;
    endtask

    task automatic waitIrq(input int limit, output int n);
        n = 0;
        while (!irq && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("irq_seen", 32'(irq), 32'd1);
    endtask

    task automatic clearDone();
        applyStimulus(3'd0, 32'hFFFF_FFFF);
        checkOutput("irq_cleared", 32'(irq), 32'd0);
    endtask

    // Bus slave models plus monitor: waitrequest is driven per beat from the
    // stall counts, and each accepted beat is checked against the queues.
    always @(negedge clock) begin
        if (rd_read) begin
            if (rd_cnt < rd_stall) begin
                rd_waitrequest = 1'b1;
                rd_cnt++;
            end else begin
                rd_waitrequest = 1'b0;
                rd_readdata    = mem_byte(rd_address);
            end
        end else begin
            rd_waitrequest = 1'b0;
            rd_cnt = 0;
        end
        if (wm_chipselect) begin
            if (wm_cnt < wm_stall) begin
                wm_waitrequest = 1'b1;
                wm_cnt++;
            end else begin
                wm_waitrequest = 1'b0;
            end
        end else begin
            wm_waitrequest = 1'b0;
            wm_cnt = 0;
        end

        if (aclr) begin
            rd_stalled = 1'b0;
            wm_stalled = 1'b0;
        end else begin
            if (rd_read && wm_chipselect) overlap_errs++;
            if (rd_read || wm_chipselect || !wm_write_n) bus_activity++;
            if (rd_stalled && (!rd_read || rd_address != rd_hold)) stall_errs++;
            if (wm_stalled && (!wm_chipselect || wm_write_n ||
                               wm_address != wa_hold || wm_writedata != wd_hold)) stall_errs++;
            rd_stalled = rd_read && rd_waitrequest;
            rd_hold    = rd_address;
            wm_stalled = wm_chipselect && wm_waitrequest;
            wa_hold    = wm_address;
            wd_hold    = wm_writedata;

            if (rd_read && !rd_waitrequest) begin
                if (exp_reads.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_read: got address 0x%0h with no read pending", rd_address);
                end else begin
                    checkOutput("rd_address", rd_address, exp_reads.pop_front());
                end
            end
            if (wm_chipselect && !wm_write_n && !wm_waitrequest) begin
                wr_rec_t w;
                write_count++;
                write_offsets.push_back(cycle_count - go_cycle);
                if (exp_writes.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got address %0d data 0x%0h with no write pending",
                             wm_address, wm_writedata);
                end else begin
                    w = exp_writes.pop_front();
                    checkOutput("wm_address", 32'(wm_address), 32'(w.addr));
                    checkOutput("wm_writedata", 32'(wm_writedata), 32'(w.data));
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        int n;

        vecs[0] = '{3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_001F, 1'b1};
        vecs[3] = '{3'd3, 32'h0001_ABCD, 32'h0000_ABCD, 1'b1};
        vecs[4] = '{3'd4, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[5] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[7] = '{3'd6, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1};
        vecs[8] = '{3'd1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[9] = '{3'd3, 32'h0000_0000, 32'h0000_0000, 1'b1};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_rd_read", 32'(rd_read), 32'd0);
        checkOutput("reset_wm_chipselect", 32'(wm_chipselect), 32'd0);
        checkOutput("reset_wm_write_n", 32'(wm_write_n), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        aclr = 1'b0;
        @(posedge clock);
        #1;
        for (int a = 0; a < 8; a++) begin
            readReg(3'(a), d);
            checkOutput("reset_reg", d, 32'd0);
        end

        // Register map table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_write) applyStimulus(vecs[i].addr, vecs[i].wdata);
            readReg(vecs[i].addr, d);
            checkOutput($sformatf("reg_vec%0d", i), d, vecs[i].rdata_exp);
        end
        readReg(3'd0, d);
        checkOutput("status_after_table", d, 32'd0);

        // Zero-wait run: 4 bytes, writes on odd cycles, DONE 8 cycles after GO
        rd_stall = 0;
        wm_stall = 0;
        setupRun(32'h1000, 5'd3, 4);
        startGo();
        waitIrq(50, n);
        checkOutput("zero_wait_cycles", 32'(n), 32'd8);
        for (int i = 0; i < 4; i++)
            checkOutput("zero_wait_write_cycle",
                        32'((i < write_offsets.size()) ? write_offsets[i] : -1), 32'(1 + 2 * i));
        readReg(3'd1, d); checkOutput("zero_wait_readaddr", d, 32'h1004);
        readReg(3'd2, d); checkOutput("zero_wait_writeaddr", d, 32'd7);
        readReg(3'd3, d); checkOutput("zero_wait_length", d, 32'd0);
        readReg(3'd0, d); checkOutput("zero_wait_status", d, 32'd1);
        checkOutput("zero_wait_queue", 32'(exp_writes.size()), 32'd0);
        clearDone();

        // Wait-state run: 7 cycles per byte
        rd_stall = 3;
        wm_stall = 2;
        setupRun(32'h2000, 5'd10, 2);
        startGo();
        waitIrq(100, n);
        checkOutput("wait_state_cycles", 32'(n), 32'd14);
        checkOutput("wait_state_writes", 32'(write_count), 32'd2);
        checkOutput("wait_state_first_write",
                    32'((write_offsets.size() > 0) ? write_offsets[0] : -1), 32'd6);
        checkOutput("wait_state_queue", 32'(exp_writes.size() + exp_reads.size()), 32'd0);
        clearDone();

        // Wrap run
        rd_stall = 0;
        wm_stall = 1;
        setupRun(32'hFFFF_FFFF, 5'd30, 3);
        startGo();
        waitIrq(100, n);
        readReg(3'd1, d); checkOutput("wrap_readaddr", d, 32'h2);
        readReg(3'd2, d); checkOutput("wrap_writeaddr", d, 32'd1);
        checkOutput("wrap_queue", 32'(exp_writes.size() + exp_reads.size()), 32'd0);
        clearDone();

        // Zero-length GO: DONE next edge, no bus activity
        wm_stall = 0;
        applyStimulus(3'd3, 32'd0);
        bus_activity = 0;
        startGo();
        checkOutput("zero_len_irq", 32'(irq), 32'd1);
        readReg(3'd0, d); checkOutput("zero_len_status", d, 32'd1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("zero_len_bus_activity", 32'(bus_activity), 32'd0);
        clearDone();

        // Writes while busy are ignored
        rd_stall = 2;
        setupRun(32'h3000, 5'd0, 3);
        startGo();
        readReg(3'd0, d); checkOutput("busy_status", d, 32'd2);
        applyStimulus(3'd3, 32'd10);
        applyStimulus(3'd6, 32'd1);
        applyStimulus(3'd1, 32'h5555);
        waitIrq(100, n);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("busy_write_count", 32'(write_count), 32'd3);
        readReg(3'd3, d); checkOutput("busy_length", d, 32'd0);
        readReg(3'd1, d); checkOutput("busy_readaddr", d, 32'h3003);
        readReg(3'd0, d); checkOutput("busy_final_status", d, 32'd1);
        clearDone();

        // STATUS write on the DONE-set edge leaves DONE set
        rd_stall = 0;
        setupRun(32'h4000, 5'd5, 1);
        startGo();
        @(posedge clock);
        #1;
        checkOutput("irq_before_done_edge", 32'(irq), 32'd0);
        applyStimulus(3'd0, 32'd0);
        checkOutput("status_on_done_edge", 32'(irq), 32'd1);
        clearDone();

        // Async reset during a WRITE stall
        wm_stall = 5;
        setupRun(32'h5000, 5'd8, 2);
        startGo();
        n = 0;
        while (!wm_chipselect && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("reset_test_in_write", 32'(wm_chipselect), 32'd1);
        #2;
        aclr = 1'b1;
        #1;
        checkOutput("async_wm_chipselect", 32'(wm_chipselect), 32'd0);
        checkOutput("async_wm_write_n", 32'(wm_write_n), 32'd1);
        checkOutput("async_rd_read", 32'(rd_read), 32'd0);
        exp_reads.delete();
        exp_writes.delete();
        repeat (2) @(posedge clock);
        #1;
        aclr = 1'b0;
        for (int a = 0; a < 4; a++) begin
            readReg(3'(a), d);
            checkOutput("post_reset_reg", d, 32'd0);
        end
        bus_activity = 0;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("post_reset_bus_activity", 32'(bus_activity), 32'd0);

        // New GO after reset resumes normally
        wm_stall = 0;
        setupRun(32'h6000, 5'd2, 1);
        startGo();
        waitIrq(50, n);
        checkOutput("post_reset_cycles", 32'(n), 32'd2);
        checkOutput("post_reset_queue", 32'(exp_writes.size() + exp_reads.size()), 32'd0);

        checkOutput("overlap_count", 32'(overlap_errs), 32'd0);
        checkOutput("stall_stability", 32'(stall_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
